// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder/decoder pair: byte width,
// escape byte that introduces a run token, and the decoder token-parsing states.
`timescale 1ns/1ps

package rle_pkg;

  localparam int          DATA_W   = 8;
  localparam logic [7:0]  ESC_CODE = 8'h1B;

  // Token parsing position: literal byte, run count byte, run value byte,
  // or expanding the repeated copies of a run.
  typedef enum logic [1:0] {
    S_LIT = 2'd0,
    S_CNT = 2'd1,
    S_VAL = 2'd2,
    S_RUN = 2'd3
  } state_e;

endpackage

// File: rtl/rldecoding.sv
// Run-length decoder. Literal bytes pass straight to a single output register;
// the token ESC_CODE,count,value expands to 'count' copies of 'value'.
// A zero count is illegal and is reported with a one-cycle proto_error pulse.
`timescale 1ns/1ps

module rldecoding #(
  parameter int                DATA_W   = rle_pkg::DATA_W,
  parameter logic [DATA_W-1:0] ESC_CODE = rle_pkg::ESC_CODE
) (
  input  logic              data_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              run_active,
  output logic              proto_error
);

  import rle_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              run_q;
  logic              proto_q, proto_d;
  logic              canLoad;
  logic              readyRaw;
  logic              inXfer;

  // The output register may take a new byte when empty or when drained this cycle.
  assign canLoad = ~valid_q | data_out_ready;

  // Input acceptance depends only on the parsing state and output-stage space;
  // it is forced low while reset is held so nothing is taken during reset.
  always_comb begin
    readyRaw = 1'b0;
    case (state_q)
      S_LIT:   readyRaw = canLoad;
      S_CNT:   readyRaw = 1'b1;
      S_VAL:   readyRaw = canLoad;
      S_RUN:   readyRaw = 1'b0;
      default: readyRaw = 1'b0;
    endcase
  end

  assign data_in_ready = reset_n & readyRaw;
  assign inXfer        = data_in_valid & data_in_ready;

  // Next-state logic: token parsing, run expansion and output-register loading.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q & ~data_out_ready;
    proto_d = 1'b0;
    case (state_q)
      S_LIT: begin
        if (inXfer) begin
          if (data_in == ESC_CODE) begin
            state_d = S_CNT;
          end else begin
            out_d   = data_in;
            valid_d = 1'b1;
          end
        end
      end
      S_CNT: begin
        if (inXfer) begin
          count_d = data_in;
          if (data_in == '0) begin
            proto_d = 1'b1;
            state_d = S_LIT;
          end else begin
            state_d = S_VAL;
          end
        end
      end
      S_VAL: begin
        if (inXfer) begin
          value_d = data_in;
          out_d   = data_in;
          valid_d = 1'b1;
          cnt_d   = count_q - 1'b1;
          state_d = (count_q > 1) ? S_RUN : S_LIT;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_LIT;
        end else if (canLoad) begin
          out_d   = value_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == 1) begin
            state_d = S_LIT;
          end
        end
      end
      default: state_d = S_LIT;
    endcase
  end

  // State and registered outputs; reset discards any partial token and pending byte.
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LIT;
      count_q <= '0;
      value_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      run_q   <= (state_d == S_RUN);
      proto_q <= proto_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = valid_q;
  assign run_active     = run_q;
  assign proto_error    = proto_q;

endmodule

// File: tb/tb_rldecoding.sv
// Directed self-checking bench for the run-length decoder.
`timescale 1ns/1ps

module tb_rldecoding;

  logic       data_clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       run_active;
  logic       proto_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] outQ[$];
  int         xferCycles[$];
  int         cycleNum = 0;
  int         runCycles, readyLowCycles, readyDuringRun, protoPulses;
  int         stableErrors, stallCycles;
  logic       toggleMode = 1'b0;
  logic       prevStalled = 1'b0;
  logic [7:0] prevData = 8'h00;

  rldecoding dut (
    .data_clk       (data_clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .run_active     (run_active),
    .proto_error    (proto_error)
  );

  // Free-running clock
  initial begin
    data_clk = 1'b0;
    forever #5 data_clk = ~data_clk;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sink-ready toggler used for backpressure scenarios
  initial begin
    forever begin
      @(posedge data_clk);
      #1;
      if (toggleMode) data_out_ready = ~data_out_ready;
    end
  end

  // Monitor sampling on the falling edge: transfers, run flag, stalls, pulses
  initial begin
    forever begin
      @(negedge data_clk);
      cycleNum++;
      if (reset_n) begin
        if (data_out_valid && data_out_ready) begin
          outQ.push_back(data_out);
          xferCycles.push_back(cycleNum);
        end
        if (run_active) runCycles++;
        if (run_active && data_in_ready) readyDuringRun++;
        if (!data_in_ready) readyLowCycles++;
        if (proto_error) protoPulses++;
        if (prevStalled && (data_out !== prevData || data_out_valid !== 1'b1)) stableErrors++;
        prevStalled = data_out_valid && !data_out_ready;
        if (prevStalled) stallCycles++;
        prevData = data_out;
      end else begin
        prevStalled = 1'b0;
      end
    end
  end

  task automatic clearStats();
    outQ.delete();
    xferCycles.delete();
    runCycles      = 0;
    readyLowCycles = 0;
    readyDuringRun = 0;
    protoPulses    = 0;
    stableErrors   = 0;
    stallCycles    = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waited;
    data_in       = b;
    data_in_valid = 1'b1;
    waited        = 0;
    @(negedge data_clk);
    while (!data_in_ready && waited < 200) begin
      waited++;
      @(negedge data_clk);
    end
    checks++;
    if (!data_in_ready) begin
      errors++;
      $display("[TB] FAIL send_timeout byte=%02h ready=%b required=1", b, data_in_ready);
    end
    @(posedge data_clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge data_clk);
    @(posedge data_clk);
    #1;
  endtask

  task automatic checkQueue(input string name, input logic [7:0] exp[$]);
    checks++;
    if (outQ.size() != exp.size()) begin
      errors++;
      $display("[TB] FAIL %s_count got=%0d expected=%0d", name, outQ.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (outQ[i] !== exp[i]) begin
          errors++;
          $display("[TB] FAIL %s_byte%0d got=%02h expected=%02h", name, i, outQ[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b1;
    data_in        = 8'h00;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    data_in_valid = 1'b1;
    data_in = 8'h41;
    repeat (3) @(posedge data_clk);
    #1;
    checks++;
    if ({data_out_valid, data_in_ready, run_active, proto_error} !== 4'b0000 || data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_values got valid=%b ready=%b run=%b perr=%b out=%02h expected all zero",
               data_out_valid, data_in_ready, run_active, proto_error, data_out);
    end
    data_in_valid = 1'b0;
    @(negedge data_clk);
    reset_n = 1'b1;
    @(posedge data_clk);
    #1;
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got=%b expected=1", data_in_ready);
    end
  endtask

  task automatic test_literals();
    logic [7:0] exp[$];
    clearStats();
    sendByte(8'h41);
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h41) begin
      errors++;
      $display("[TB] FAIL literal_latency got valid=%b out=%02h expected valid=1 out=41",
               data_out_valid, data_out);
    end
    sendByte(8'h42);
    sendByte(8'h43);
    drain(5);
    exp = '{8'h41, 8'h42, 8'h43};
    checkQueue("literals", exp);
    checks++;
    if (xferCycles.size() != 3 || xferCycles[2] - xferCycles[0] != 2) begin
      errors++;
      $display("[TB] FAIL literal_back_to_back got transfers=%0d expected 3 on consecutive cycles",
               xferCycles.size());
    end
  endtask

  task automatic test_run();
    logic [7:0] exp[$];
    clearStats();
    sendByte(8'h1B);
    sendByte(8'h05);
    sendByte(8'h7E);
    drain(10);
    exp = '{8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h7E};
    checkQueue("run5", exp);
    checks++;
    if (xferCycles.size() != 5 || xferCycles[4] - xferCycles[0] != 4) begin
      errors++;
      $display("[TB] FAIL run5_consecutive got transfers=%0d expected 5 consecutive", xferCycles.size());
    end
    checks++;
    if (runCycles != 4) begin
      errors++;
      $display("[TB] FAIL run5_active_cycles got=%0d expected=4", runCycles);
    end
    checks++;
    if (readyLowCycles != 4 || readyDuringRun != 0) begin
      errors++;
      $display("[TB] FAIL run5_ready_low got low=%0d ready_in_run=%0d expected low=4 ready_in_run=0",
               readyLowCycles, readyDuringRun);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    clearStats();
    data_out_ready = 1'b1;
    toggleMode     = 1'b1;
    sendByte(8'h1B);
    sendByte(8'h03);
    sendByte(8'h55);
    drain(12);
    toggleMode     = 1'b0;
    data_out_ready = 1'b1;
    drain(2);
    exp = '{8'h55, 8'h55, 8'h55};
    checkQueue("stall_run3", exp);
    checks++;
    if (stallCycles == 0) begin
      errors++;
      $display("[TB] FAIL stall_seen got stalls=%0d expected at least 1", stallCycles);
    end
    checks++;
    if (stableErrors != 0) begin
      errors++;
      $display("[TB] FAIL stall_stable got changes=%0d expected=0", stableErrors);
    end
  endtask

  task automatic test_zero_count();
    logic [7:0] exp[$];
    clearStats();
    sendByte(8'h1B);
    sendByte(8'h00);
    checks++;
    if (proto_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL proto_pulse got=%b expected=1", proto_error);
    end
    sendByte(8'h11);
    checks++;
    if (proto_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL proto_one_cycle got=%b expected=0", proto_error);
    end
    drain(4);
    checks++;
    if (protoPulses != 1) begin
      errors++;
      $display("[TB] FAIL proto_count got=%0d expected=1", protoPulses);
    end
    exp = '{8'h11};
    checkQueue("after_zero", exp);
  endtask

  task automatic test_escape_value();
    logic [7:0] exp[$];
    clearStats();
    sendByte(8'h1B);
    sendByte(8'h01);
    sendByte(8'h1B);
    sendByte(8'h20);
    drain(4);
    exp = '{8'h1B, 8'h20};
    checkQueue("esc_value", exp);
    checks++;
    if (runCycles != 0) begin
      errors++;
      $display("[TB] FAIL esc_value_run got=%0d expected=0", runCycles);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp[$];
    int waited;
    clearStats();
    sendByte(8'h1B);
    sendByte(8'hFF);
    sendByte(8'h99);
    waited = 0;
    while (outQ.size() < 10 && waited < 50) begin
      @(negedge data_clk);
      waited++;
    end
    checks++;
    if (outQ.size() < 10) begin
      errors++;
      $display("[TB] FAIL midrun_copies got=%0d expected>=10", outQ.size());
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 1'b0 || run_active !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrun_reset got valid=%b ready=%b run=%b out=%02h expected 0 0 0 00",
               data_out_valid, data_in_ready, run_active, data_out);
    end
    repeat (2) @(posedge data_clk);
    @(negedge data_clk);
    reset_n = 1'b1;
    @(posedge data_clk);
    #1;
    clearStats();
    sendByte(8'h33);
    drain(6);
    exp = '{8'h33};
    checkQueue("after_reset", exp);
    checks++;
    if (runCycles != 0) begin
      errors++;
      $display("[TB] FAIL after_reset_run got=%0d expected=0", runCycles);
    end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_run();
    test_backpressure();
    test_zero_count();
    test_escape_value();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
